rom_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the single-cycle CPU. Owns the program counter and drives the word address of the combinational instruction ROM (ROM_A).
- Registers each fetched instruction and its PC into a one-entry valid/ready output stage toward decode.
- Supports redirect (branch/jump), stall by backpressure, halt/resume, and auto-halt on a sentinel instruction.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/rom_fetch_ctrl.sv | 97 +++++++++
 tb/tb_rom_fetch_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch sequencer state encoding, PC step and
// the default reset vector / halt sentinel.
package cpu_pkg;

   typedef enum logic [1:0] {
      FS_BOOT = 2'd0,
      FS_RUN  = 2'd1,
      FS_HALT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] PC_STEP           = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_HALT_INST = 32'hFFFF_FFFF;

   // Byte address to ROM word address.
   function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
      return {2'b00, byte_addr[31:2]};
   endfunction

endpackage

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the combinational ROM
// and registers each instruction into a one-entry valid/ready stage.
module rom_fetch_ctrl
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [31:0] HALT_INST = DEFAULT_HALT_INST
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_inst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   input  logic        resume,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   output logic        halted,
   output logic [31:0] fetch_count
);

   fetch_state_t state_reg;
   logic [31:0]  pc_reg;
   logic         valid_reg;
   logic [31:0]  inst_reg;
   logic [31:0]  ipc_reg;
   logic [31:0]  count_reg;

   logic         consume;
   logic         capture;

   assign consume = valid_reg && if_ready;
   assign capture = (state_reg == FS_RUN) && (!valid_reg || if_ready) &&
                    !redirect_valid && !halt_req;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= FS_BOOT;
         pc_reg    <= RESET_PC;
         valid_reg <= 1'b0;
         inst_reg  <= 32'd0;
         ipc_reg   <= 32'd0;
         count_reg <= 32'd0;
      end else begin
         // The handshake counts even when a redirect flushes the stage.
         if (consume)
            count_reg <= count_reg + 32'd1;

         if (redirect_valid) begin
            pc_reg    <= {redirect_pc[31:2], 2'b00};
            valid_reg <= 1'b0;
         end else begin
            case (state_reg)
               FS_BOOT: begin
                  state_reg <= FS_RUN;
               end
               FS_RUN: begin
                  if (capture) begin
                     inst_reg  <= rom_inst;
                     ipc_reg   <= pc_reg;
                     valid_reg <= 1'b1;
                     pc_reg    <= pc_reg + PC_STEP;
                     if (rom_inst == HALT_INST)
                        state_reg <= FS_HALT;
                  end else begin
                     if (consume)
                        valid_reg <= 1'b0;
                     if (halt_req)
                        state_reg <= FS_HALT;
                  end
               end
               FS_HALT: begin
                  if (consume)
                     valid_reg <= 1'b0;
                  if (resume && !halt_req)
                     state_reg <= FS_RUN;
               end
               default: begin
                  state_reg <= FS_BOOT;
                  valid_reg <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rom_addr    = word_addr(pc_reg);
   assign if_valid    = valid_reg;
   assign if_inst     = inst_reg;
   assign if_pc       = ipc_reg;
   assign fetch_count = count_reg;
   assign halted      = (state_reg == FS_HALT);

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed bench for rom_fetch_ctrl; accepted transfers are matched against
// a queue of expected {inst, pc} pairs.
module tb_rom_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] rom_addr;
   logic [31:0] rom_inst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic        resume;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        halted;
   logic [31:0] fetch_count;

   logic        halt_word_en;
   logic [63:0] exp_q[$];
   int          passed = 0;
   int          failed = 0;
   int          total  = 0;

   always #5 clk = ~clk;

   // ROM word i holds i, except word 5 becomes the halt sentinel on demand.
   assign rom_inst = (halt_word_en && rom_addr == 32'd5) ? 32'hFFFF_FFFF : rom_addr;

   rom_fetch_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rom_addr       (rom_addr),
      .rom_inst       (rom_inst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .resume         (resume),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_inst        (if_inst),
      .if_pc          (if_pc),
      .halted         (halted),
      .fetch_count    (fetch_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] inst, input logic [31:0] pc);
      exp_q.push_back({inst, pc});
   endtask

   // Transfers happen on the next rising edge when valid && ready at the falling edge.
   always @(negedge clk) begin
      if (rst_n && if_valid && if_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_xfer", if_pc, 32'hDEAD_BEEF);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            $display("xfer inst=%h pc=%h exp_inst=%h exp_pc=%h", if_inst, if_pc, e[63:32], e[31:0]);
            chk("xfer_inst", if_inst, e[63:32]);
            chk("xfer_pc", if_pc, e[31:0]);
         end
      end
   end

   initial begin
      rst_n = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
      halt_req = 1'b0; resume = 1'b0; halt_word_en = 1'b0;
      step(); step();
      rst_n = 1'b1;
      chk("rst_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_count", fetch_count, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_addr", rom_addr, 32'd0);
      chk("rst_inst", if_inst, 32'd0);
      push(0, 0); push(1, 4); push(2, 8); push(3, 12); push(4, 16);
      step();
      chk("boot_valid", {31'd0, if_valid}, 32'd0);
      step();
      chk("run_pc0", if_pc, 32'd0);
      chk("run_valid", {31'd0, if_valid}, 32'd1);
      step();
      chk("run_pc4", if_pc, 32'd4);
      step();
      chk("run_pc8", if_pc, 32'd8);
      // Backpressure for three edges while pc=8 is held.
      if_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_pc", if_pc, 32'd8);
         chk("bp_inst", if_inst, 32'd2);
         chk("bp_addr", rom_addr, 32'd3);
      end
      if_ready = 1'b1;
      step();
      chk("rel_pc12", if_pc, 32'd12);
      step();
      chk("count4", fetch_count, 32'd4);
      chk("pc16", if_pc, 32'd16);
      // Redirect while valid; the pc=16 entry is accepted on the same edge.
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
      push(32'h40, 32'h100);
      step();
      redirect_valid = 1'b0;
      chk("redir_flush", {31'd0, if_valid}, 32'd0);
      chk("redir_addr", rom_addr, 32'h40);
      chk("redir_count", fetch_count, 32'd5);
      step();
      chk("redir_pc", if_pc, 32'h100);
      chk("redir_valid", {31'd0, if_valid}, 32'd1);
      // Wrap around the top of the address space.
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      push(32'h3FFF_FFFF, 32'hFFFF_FFFC); push(0, 0);
      step();
      redirect_valid = 1'b0;
      chk("wrap_addr_hi", rom_addr, 32'h3FFF_FFFF);
      step();
      chk("wrap_pc_hi", if_pc, 32'hFFFF_FFFC);
      chk("wrap_addr0", rom_addr, 32'd0);
      step();
      chk("wrap_pc0", if_pc, 32'd0);
      // Halt and resume together: halt wins.
      halt_req = 1'b1; resume = 1'b1;
      step();
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_drain", {31'd0, if_valid}, 32'd0);
      step();
      chk("halt_stay", {31'd0, halted}, 32'd1);
      chk("halt_addr", rom_addr, 32'd1);
      halt_req = 1'b0; halt_word_en = 1'b1;
      push(1, 4); push(2, 8); push(3, 12); push(4, 16); push(32'hFFFF_FFFF, 20);
      step();
      resume = 1'b0;
      chk("resume_run", {31'd0, halted}, 32'd0);
      step();
      chk("resume_pc", if_pc, 32'd4);
      step(); step(); step(); step();
      chk("ahalt_inst", if_inst, 32'hFFFF_FFFF);
      chk("ahalt_pc", if_pc, 32'd20);
      chk("ahalt_halted", {31'd0, halted}, 32'd1);
      chk("ahalt_addr", rom_addr, 32'd6);
      step(); step(); step();
      chk("ahalt_idle", {31'd0, if_valid}, 32'd0);
      chk("ahalt_count", fetch_count, 32'd13);
      chk("ahalt_addr2", rom_addr, 32'd6);
      // Leave HALT, hold an entry, then reset mid-run.
      halt_word_en = 1'b0; resume = 1'b1; if_ready = 1'b0;
      step();
      resume = 1'b0;
      step();
      chk("pre_rst_valid", {31'd0, if_valid}, 32'd1);
      chk("pre_rst_pc", if_pc, 32'd24);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; if_ready = 1'b1;
      chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
      chk("mid_rst_count", fetch_count, 32'd0);
      chk("mid_rst_addr", rom_addr, 32'd0);
      push(0, 0);
      step();
      chk("mid_boot_valid", {31'd0, if_valid}, 32'd0);
      step();
      chk("mid_first_pc", if_pc, 32'd0);
      chk("mid_first_valid", {31'd0, if_valid}, 32'd1);
      step();
      if_ready = 1'b0;
      step();
      chk("queue_empty", exp_q.size(), 32'd0);
      chk("end_count", fetch_count, 32'd1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
